// File: rtl/ec_strobe_gen_pkg.sv
// Shared types, reset values and width helpers for the EC strobe generator
// and the tick_div prescaler it instantiates.
package ec_strobe_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } state_t;

  localparam state_t STATE_RST = IDLE;
  localparam logic   BIT_RST   = 1'b0;

  // Number of bits needed to hold the value v (at least 1).
  function automatic int bits_for(input int unsigned v);
    int n;
    n = 1;
    for (int i = 1; i < 32; i++) begin
      if ((v >> i) != 0) n = i + 1;
    end
    return n;
  endfunction

  function automatic int max_w(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ec_strobe_gen_if.sv
// Button/strobe bundle between the strobe generator and its user.
// No valid/ready here: EC is a one-cycle strobe, consumed in the cycle it is high.
interface ec_strobe_gen_if;
  import ec_strobe_pkg::*;

  logic   btn;
  logic   run;
  logic   EC;
  logic   btn_db;
  logic   rpt;
  state_t state;

  modport master (output btn, run, input EC, btn_db, rpt, state);
  modport slave  (input btn, run, output EC, btn_db, rpt, state);
endinterface

// File: rtl/ec_strobe_gen_tick_div.sv
// Free-running prescaler: tick is high for one cycle every DIV clocks,
// first on the DIV-th cycle after reset.
module tick_div
  import ec_strobe_pkg::*;
#(
  parameter int DIV_W = 16,
  parameter int DIV   = 50000
) (
  input  logic clk,
  input  logic r,
  output logic tick
);

  localparam int               CNT_W = max_w(DIV_W, bits_for(DIV - 1));
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick  = (cnt_q == LAST);
  assign cnt_d = tick ? '0 : cnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (r) cnt_q <= '0;
    else   cnt_q <= cnt_d;
  end

endmodule

// File: rtl/ec_strobe_gen.sv
// Count-enable strobe generator: debounced push-button with hold-to-repeat,
// or a fixed tick-rate strobe when run is high.
module ec_strobe_gen
  import ec_strobe_pkg::*;
#(
  parameter int DIV_W        = 16,
  parameter int DIV          = 50000,
  parameter int DB_W         = 4,
  parameter int STABLE_TICKS = 4,
  parameter int RPT_W        = 8,
  parameter int REPEAT_DELAY = 32,
  parameter int REPEAT_RATE  = 8
) (
  input logic           clk,
  input logic           r,
  ec_strobe_gen_if.slave bus
);

  localparam int DBC_W = max_w(DB_W, bits_for(STABLE_TICKS));
  localparam int RPC_W = max_w(RPT_W, bits_for(REPEAT_DELAY));

  logic             tick;
  logic             sync1_q, sync2_q;
  logic             db_q, db_d, db_prev_q;
  logic [DBC_W-1:0] dbcnt_q, dbcnt_d;
  state_t           state_q, state_d;
  logic [RPC_W-1:0] rptcnt_q, rptcnt_d, rpt_inc;
  logic             ec_q, ec_d;
  logic             fire, press, rel;

  tick_div #(.DIV_W(DIV_W), .DIV(DIV)) u_tick_div (
    .clk  (clk),
    .r    (r),
    .tick (tick)
  );

  // Any cycle where the synced input matches the accepted level restarts qualification.
  always_comb begin
    db_d    = db_q;
    dbcnt_d = dbcnt_q;
    if (sync2_q == db_q) begin
      dbcnt_d = '0;
    end else if (tick) begin
      if (dbcnt_q == DBC_W'(STABLE_TICKS - 1)) begin
        db_d    = ~db_q;
        dbcnt_d = '0;
      end else begin
        dbcnt_d = dbcnt_q + 1'b1;
      end
    end
  end

  assign press   = db_q & ~db_prev_q;
  assign rel     = ~db_q & db_prev_q;
  assign rpt_inc = rptcnt_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    rptcnt_d = rptcnt_q;
    fire     = 1'b0;
    if (bus.run) begin
      state_d  = IDLE;
      rptcnt_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (press) begin
            state_d  = HOLD;
            rptcnt_d = '0;
            fire     = 1'b1;
          end
        end
        HOLD: begin
          if (rel) begin
            state_d = IDLE;
          end else if (tick) begin
            if (rpt_inc == RPC_W'(REPEAT_DELAY)) begin
              state_d  = REPEAT;
              rptcnt_d = '0;
              fire     = 1'b1;
            end else begin
              rptcnt_d = rpt_inc;
            end
          end
        end
        REPEAT: begin
          if (rel) begin
            state_d = IDLE;
          end else if (tick) begin
            if (rpt_inc == RPC_W'(REPEAT_RATE)) begin
              rptcnt_d = '0;
              fire     = 1'b1;
            end else begin
              rptcnt_d = rpt_inc;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign ec_d = bus.run ? tick : fire;

  always_ff @(posedge clk) begin
    if (r) begin
      sync1_q   <= BIT_RST;
      sync2_q   <= BIT_RST;
      db_q      <= BIT_RST;
      db_prev_q <= BIT_RST;
      dbcnt_q   <= '0;
      state_q   <= STATE_RST;
      rptcnt_q  <= '0;
      ec_q      <= BIT_RST;
    end else begin
      sync1_q   <= bus.btn;
      sync2_q   <= sync1_q;
      db_q      <= db_d;
      db_prev_q <= db_q;
      dbcnt_q   <= dbcnt_d;
      state_q   <= state_d;
      rptcnt_q  <= rptcnt_d;
      ec_q      <= ec_d;
    end
  end

  assign bus.EC     = ec_q;
  assign bus.btn_db = db_q;
  assign bus.rpt    = (state_q == REPEAT);
  assign bus.state  = state_q;

endmodule

// File: doc/ec_strobe_gen.md
Name: ec_strobe_gen

Overview:
- Upstream stage of the 4-bit enable-gated counter; produces its count-enable strobe EC.
- Turns a raw, bouncing push-button into clean single-cycle EC pulses, with hold-to-auto-repeat.
- Also has a free-run mode in which EC pulses at a fixed prescaled rate.
- EC drives the counter's enable input directly, in the same clk domain.

Parameters:
- DIV_W, 16, width of prescaler counter.
- DIV, 50000, clk cycles per tick; legal range 2..2^DIV_W.
- DB_W, 4, width of debounce counter.
- STABLE_TICKS, 4, consecutive ticks input must differ from debounced level before it is accepted; 1..2^DB_W-1.
- RPT_W, 8, width of repeat counter.
- REPEAT_DELAY, 32, ticks of continuous hold before auto-repeat starts; 1..2^RPT_W-1.
- REPEAT_RATE, 8, ticks between auto-repeat pulses; 1..REPEAT_DELAY.

Ports:
- clk  in  1  system clock; all state on rising edge.
- r  in  1  synchronous, active-high reset.
- btn  in  1  raw button, asynchronous to clk, active-high.
- run  in  1  free-run select; synchronous to clk.
- EC  out  1  registered count-enable strobe, one clk cycle wide.
- btn_db  out  1  debounced button level.
- rpt  out  1  high while FSM is in REPEAT.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset (r=1 at a clk edge) clears, at that edge:
  - prescaler, sync flops, debounce counter, repeat counter;
  - btn_db=0, EC=0, rpt=0, FSM=IDLE.
  - Reset mid-hold or mid-repeat aborts with no further EC. After r falls, a still-pressed btn is treated as a new press.
- Prescaler:
  - cnt counts 0..DIV-1 and wraps to 0.
  - tick=1 in the cycle cnt==DIV-1.
  - First tick after reset is the DIV-th cycle.
- Synchronizer: two flops, reset 0. The sync value lags btn by 2 cycles.
- Debounce:
  - On any cycle sync==btn_db, the db counter clears to 0.
  - On a tick with sync!=btn_db, the db counter increments.
  - When it would reach STABLE_TICKS, btn_db toggles and the counter clears, in the same edge.
  - Counter never wraps.
- press = btn_db rising (registered 0->1 of btn_db). release = btn_db falling.
- FSM (states in package):
  - IDLE: on press -> HOLD, rptcnt=0, fire.
  - HOLD: on release -> IDLE. On tick, rptcnt++. When rptcnt reaches REPEAT_DELAY -> REPEAT, rptcnt=0, fire.
  - REPEAT: on release -> IDLE. On tick, rptcnt++. When rptcnt reaches REPEAT_RATE, rptcnt=0, fire.
  - release takes priority over a same-cycle tick; no fire on that cycle.
- EC register:
  - run=0: EC next cycle = fire.
  - run=1: EC next cycle = tick. The FSM is held in IDLE and rpt=0, but debounce keeps running, and a press while run=1 does not fire.
  - run 1->0 with button held: no EC until release followed by a new press.
  - At most one EC per cycle; EC is never high in two consecutive cycles (DIV>=2).
- Latency:
  - EC rises 1 cycle after the btn_db rise.
  - btn_db rises on the tick edge at which the debounce counter reaches STABLE_TICKS. That is the STABLE_TICKS-th tick whose cycle sees sync==1, with sync 2 cycles behind btn.
- A bounce (sync returning to btn_db) at any point restarts qualification from 0.
- rpt = (state==REPEAT).

Decomposition:
- Package ec_strobe_pkg holds:
  - state enum {IDLE, HOLD, REPEAT}, 2 bits;
  - reset-value constants;
  - helper function for the counter widths needed for the parameter ranges.
- One sub-module, tick_div:
  - prescaler (params DIV_W, DIV; ports clk, r, tick);
  - reused by later display-scan and blink blocks.
- Synchronizer, debounce and FSM stay inline.

Test Plan (sim params DIV=4, STABLE_TICKS=3, REPEAT_DELAY=5, REPEAT_RATE=2):
1. Reset then idle 40 cycles, btn=0, run=0 -> EC, btn_db, rpt all stay 0; first tick on cycle 4 after reset release.
2. Clean press, btn=1 held 30 cycles -> btn_db rises on the 3rd qualifying tick edge; EC is one 1-cycle pulse on the next cycle; exactly one EC; rpt=0.
3. Bounce: btn toggles 1/0 every 3 cycles for 40 cycles, then 0 -> btn_db never rises; EC=0 throughout.
4. Hold for 100 cycles -> EC at press; second EC 5 ticks (20 cycles) later with rpt=1; then EC every 8 cycles; on release plus 3 ticks, btn_db=0, rpt=0, no further EC.
5. run=1 for 40 cycles with btn=0 -> EC pulses every 4 cycles, aligned to tick, 10 pulses. Raising btn during run -> no extra EC. Dropping run with btn held -> EC=0 until re-press.
6. r=1 for 1 cycle during REPEAT with btn held -> next cycle EC=0, rpt=0, btn_db=0. After 2+3 ticks of qualification, one new EC (press re-detected).
